// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings and helpers for the sram-like channel arbiter.
package sram_like_arbiter_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam int unsigned ARB_DEF_NUM_CH = 2;
   localparam int unsigned ARB_ID_W       = $clog2(ARB_DEF_NUM_CH);

   // A single channel still needs a 1-bit ID so the FIFO has non-zero width.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sram_like_arbiter_outst_fifo.sv
// In-order FIFO of channel IDs for transactions accepted by the slave but not yet answered.
module outst_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ID_W  = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic [ID_W-1:0] push_id,
   input  logic            pop,
   output logic            full,
   output logic            empty,
   output logic [ID_W-1:0] head_id
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ID_W-1:0]  mem_q [DEPTH];
   logic [ID_W-1:0]  mem_d [DEPTH];
   logic             do_push, do_pop;

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign head_id = mem_q[head_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d  = mem_q;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (do_push) begin
         mem_d[tail_q] = push_id;
         tail_d        = tail_q + 1'b1;
      end
      if (do_pop) begin
         head_d = head_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         mem_q  <= '{default: '0};
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         mem_q  <= mem_d;
      end
   end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave among NUM_CH masters; grants address phases and
// steers the in-order responses back to the issuing channel.
module sram_like_arbiter
   import sram_like_arbiter_pkg::*;
#(
   parameter int unsigned NUM_CH   = 2,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_OUTS = 4,
   parameter int unsigned RR_MODE  = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        m_req,
   input  logic [NUM_CH-1:0]        m_wr,
   input  logic [2*NUM_CH-1:0]      m_size,
   input  logic [ADDR_W*NUM_CH-1:0] m_addr,
   input  logic [DATA_W*NUM_CH-1:0] m_wdata,
   output logic [NUM_CH-1:0]        m_addr_ok,
   output logic [NUM_CH-1:0]        m_data_ok,
   output logic [DATA_W-1:0]        m_rdata,
   output logic                     s_req,
   output logic                     s_wr,
   output logic [1:0]               s_size,
   output logic [ADDR_W-1:0]        s_addr,
   output logic [DATA_W-1:0]        s_wdata,
   input  logic                     s_addr_ok,
   input  logic                     s_data_ok,
   input  logic [DATA_W-1:0]        s_rdata,
   output logic                     err_unexp
);

   localparam int unsigned ID_W = id_width(NUM_CH);

   logic            lock_q, lock_d;
   logic [ID_W-1:0] lock_id_q, lock_id_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic            err_q, err_d;
   logic [ID_W-1:0] grant;
   logic [ID_W-1:0] head_id;
   logic            arb_found;
   logic            full, empty, hs, pop;
   int unsigned     idx;

   // A stalled request pins the grant so the slave sees a stable address phase.
   always_comb begin
      grant     = '0;
      arb_found = 1'b0;
      idx       = 0;
      if (lock_q) begin
         grant = lock_id_q;
      end else if (RR_MODE == 0) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!arb_found && m_req[i]) begin
               grant     = ID_W'(i);
               arb_found = 1'b1;
            end
         end
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_CH;
            if (!arb_found && m_req[ID_W'(idx)]) begin
               grant     = ID_W'(idx);
               arb_found = 1'b1;
            end
         end
      end
   end

   assign s_req   = (|m_req) && !full && !reset;
   assign s_wr    = m_wr[grant];
   assign s_size  = m_size[grant*2 +: 2];
   assign s_addr  = m_addr[grant*ADDR_W +: ADDR_W];
   assign s_wdata = m_wdata[grant*DATA_W +: DATA_W];
   assign hs      = s_req && s_addr_ok;
   assign pop     = s_data_ok && !empty && !reset;
   assign m_rdata = s_rdata;
   assign err_unexp = err_q;

   always_comb begin
      m_addr_ok = '0;
      m_data_ok = '0;
      if (hs)  m_addr_ok[grant]   = 1'b1;
      if (pop) m_data_ok[head_id] = 1'b1;
   end

   always_comb begin
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      rr_ptr_d  = rr_ptr_q;
      err_d     = err_q | (s_data_ok && empty);
      if (hs) begin
         lock_d = 1'b0;
         if (RR_MODE != 0) begin
            rr_ptr_d = (32'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
         end
      end else if (s_req) begin
         lock_d    = 1'b1;
         lock_id_d = grant;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_q    <= 1'b0;
         lock_id_q <= '0;
         rr_ptr_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         rr_ptr_q  <= rr_ptr_d;
         err_q     <= err_d;
      end
   end

   outst_fifo #(
      .DEPTH (MAX_OUTS),
      .ID_W  (ID_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (hs),
      .push_id (grant),
      .pop     (pop),
      .full    (full),
      .empty   (empty),
      .head_id (head_id)
   );

endmodule
